mul_cmd_sequencer: RTL and testbench
====================================

MUL_CMD_SEQUENCER -- requirements
Module: mul_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction buffer entries; power of two, minimum 2.
REQ-002 Parameter LS_GAP, default 2, idle cycles after each ExLdSt pulse; range 0..15.
REQ-003 clk  input  1  single clock; every flop updates on the rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 instr_valid  input  1  host offers an instruction.
REQ-006 instr_ready  output  1  buffer accepts an instruction this cycle.
REQ-007 instr_data  input  32  [31:30] opcode (00 NOP, 01 LDST, 10 COMPUTE, 11 BARRIER), [29] flag, [24:0] payload.
REQ-008 ExLdSt_valid  output  1  one-cycle load/store strobe to the multiply controller.
REQ-009 ExLdSt_command  output  7  payload[6:0] of the LDST instruction.
REQ-010 Compute_valid  output  1  compute request to the multiply controller.
REQ-011 Compute_command  output  25  payload[24:0] of the COMPUTE instruction.
REQ-012 Compute_ready  input  1  multiply controller accepts or is idle.
REQ-013 F_in  output  1  flag bit [29] of the most recently issued LDST or COMPUTE instruction.
REQ-014 seq_idle  output  1  buffer empty and FSM in IDLE.
REQ-015 issued_cnt  output  16  count of LDST and COMPUTE instructions completed.

Function
REQ-016 instr_ready SHALL equal NOT full; a push occurs when instr_valid and instr_ready are high at a clock edge.
REQ-017 The FIFO SHALL use wrapping read and write pointers with one extra bit to tell full from empty; a simultaneous push and pop SHALL leave the count unchanged.
REQ-018 FSM states SHALL be IDLE, DECODE, LS_ISSUE, LS_WAIT, CMP_ISSUE and BARRIER.
REQ-019 From IDLE, if the FIFO is not empty, the FSM SHALL pop the head entry into an instruction register and go to DECODE; otherwise it stays in IDLE.
REQ-020 DECODE SHALL route by opcode:
  - NOP: to IDLE; no output; no count.
  - LDST: to LS_ISSUE.
  - COMPUTE: to CMP_ISSUE.
  - BARRIER: to BARRIER.
REQ-021 LS_ISSUE SHALL assert ExLdSt_valid for exactly one cycle, with ExLdSt_command and F_in taken from the instruction register.
REQ-022 After LS_ISSUE the FSM SHALL go to LS_WAIT for LS_GAP cycles (0 means go straight to IDLE), then to IDLE.
REQ-023 In CMP_ISSUE, Compute_valid and Compute_command SHALL stay high and stable until a clock edge where Compute_ready is 1.
REQ-024 On that Compute_ready edge, Compute_valid SHALL drop on the next cycle and the FSM SHALL return to IDLE.
REQ-025 BARRIER SHALL hold until Compute_ready has been 1 for two consecutive cycles, then go to IDLE.
REQ-026 issued_cnt SHALL increment by 1 at each LDST strobe and each Compute handshake, and SHALL wrap from 0xFFFF to 0.
REQ-027 Minimum issue latency SHALL be 3 cycles from push into an empty idle sequencer to the output strobe: push edge, pop edge, decode edge.
REQ-028 Whenever not in LS_ISSUE, ExLdSt_command SHALL read 0.
REQ-029 Whenever Compute_valid is 0, Compute_command SHALL hold its last value.

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL set:
  - FIFO pointers, FSM (to IDLE), gap counter, BARRIER counter and issued_cnt to 0;
  - ExLdSt_valid, Compute_valid, ExLdSt_command, Compute_command and F_in to 0;
  - seq_idle to 1, instr_ready to 1.
REQ-031 A reset during CMP_ISSUE or BARRIER SHALL drop Compute_valid on the following cycle and discard all buffered instructions.

Structure
REQ-032 Opcode encodings, field bit positions and FSM state encodings SHALL live in the shared defines file alongside Row_num and Col_num.
REQ-033 The instruction FIFO SHALL be one sub-module, cmd_fifo, with parameters FIFO_DEPTH and width 32, and ports push, pop, din, dout, full and empty.

Verification
REQ-034 Push LDST 0x5A (flag 1) after reset -> ExLdSt_valid pulses once, 3 cycles after the push, with command 0x5A and F_in=1; issued_cnt=1; seq_idle returns after the LS_GAP of 2 cycles.
REQ-035 Push COMPUTE 0x1ABCDEF with Compute_ready held 0 for 5 cycles, then 1 -> Compute_valid is high 6 cycles with a stable command and drops 1 cycle after the handshake edge; issued_cnt increments once.
REQ-036 Push 5 instructions back-to-back with Compute_ready=0 (depth 4) -> instr_ready falls after 4 accepts; the 5th is accepted only after the first pop; issue order is preserved.
REQ-037 Sequence LDST, BARRIER, LDST with Compute_ready pulsed 1-0-1-1 -> the second LDST strobe comes only after the two consecutive ready cycles.
REQ-038 Reset asserted mid-CMP_ISSUE with 3 entries buffered -> Compute_valid is 0 the next cycle; seq_idle=1; no further strobes after reset releases.
REQ-039 Preload issued_cnt to 0xFFFF by forcing, then issue one NOP and one LDST -> the NOP leaves the count unchanged; the LDST wraps it to 0x0000.

Source files
------------

// File: rtl/mul_cmd_sequencer_pkg.sv
// Shared opcode, field-position and FSM-state definitions for the multiply command sequencer.
// Also carries the array geometry used by the downstream multiply controller.
package mul_cmd_sequencer_pkg;

   localparam int Row_num = 8;
   localparam int Col_num = 8;

   localparam int INSTR_W   = 32;
   localparam int OPC_HI    = 31;
   localparam int OPC_LO    = 30;
   localparam int FLAG_BIT  = 29;
   localparam int LS_CMD_W  = 7;
   localparam int CMP_CMD_W = 25;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LDST = 2'b01;
   localparam logic [1:0] OP_CMP  = 2'b10;
   localparam logic [1:0] OP_BAR  = 2'b11;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_LS_ISSUE  = 3'd2;
   localparam logic [2:0] ST_LS_WAIT   = 3'd3;
   localparam logic [2:0] ST_CMP_ISSUE = 3'd4;
   localparam logic [2:0] ST_BARRIER   = 3'd5;

   typedef struct packed {
      logic [1:0]           opcode;
      logic                 flag;
      logic [3:0]           rsvd;
      logic [CMP_CMD_W-1:0] payload;
   } instr_t;

endpackage

// File: rtl/mul_cmd_sequencer_if.sv
// Host instruction handshake plus the load/store and compute channels to the multiply controller.
// slave is the sequencer's view; master is the host/controller side.
interface mul_cmd_sequencer_if;
   import mul_cmd_sequencer_pkg::*;

   logic                 instr_valid;
   logic                 instr_ready;
   logic [INSTR_W-1:0]   instr_data;
   logic                 ExLdSt_valid;
   logic [LS_CMD_W-1:0]  ExLdSt_command;
   logic                 Compute_valid;
   logic [CMP_CMD_W-1:0] Compute_command;
   logic                 Compute_ready;
   logic                 F_in;

   modport slave (
      input  instr_valid, instr_data, Compute_ready,
      output instr_ready, ExLdSt_valid, ExLdSt_command, Compute_valid, Compute_command, F_in
   );

   modport master (
      output instr_valid, instr_data, Compute_ready,
      input  instr_ready, ExLdSt_valid, ExLdSt_command, Compute_valid, Compute_command, F_in
   );

endinterface

// File: rtl/mul_cmd_sequencer_cmd_fifo.sv
// Instruction buffer: pointer-based FIFO, data visible at dout the cycle after a push lands.
// Push is ignored while full, pop ignored while empty; push and pop together keep the occupancy.
module cmd_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // The extra MSB distinguishes a full buffer from an empty one when the index bits match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mul_cmd_sequencer.sv
// Buffers host instructions and issues them as load/store strobes or compute requests; 3 cycles push-to-strobe minimum.
// instr_ready drops while the buffer is full; compute requests hold until Compute_ready.
module mul_cmd_sequencer
   import mul_cmd_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LS_GAP     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mul_cmd_sequencer_if.slave    bus,
   output logic                  seq_idle,
   output logic [15:0]           issued_cnt
);
   localparam logic [3:0] GAP_LAST = (LS_GAP > 0) ? 4'(LS_GAP - 1) : 4'd0;

   logic [2:0]           state;
   instr_t               instr_q;
   logic [3:0]           gap_cnt;
   logic                 bar_seen;
   logic [15:0]          cnt_q;
   logic [CMP_CMD_W-1:0] cmp_cmd_q;
   logic                 flag_q;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [INSTR_W-1:0]   fifo_dout;
   logic                 rsvd_unused;

   assign fifo_pop        = (state == ST_IDLE) && !fifo_empty;
   assign bus.instr_ready = !fifo_full;

   cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (INSTR_W)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.instr_valid && !fifo_full),
      .pop   (fifo_pop),
      .din   (bus.instr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Reserved instruction bits carry no meaning for the sequencer.
   assign rsvd_unused = ^instr_q.rsvd;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         instr_q   <= '0;
         gap_cnt   <= '0;
         bar_seen  <= 1'b0;
         cnt_q     <= '0;
         cmp_cmd_q <= '0;
         flag_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  instr_q <= instr_t'(fifo_dout);
                  state   <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               case (instr_q.opcode)
                  OP_LDST: begin
                     flag_q <= instr_q.flag;
                     state  <= ST_LS_ISSUE;
                  end
                  OP_CMP: begin
                     flag_q    <= instr_q.flag;
                     cmp_cmd_q <= instr_q.payload;
                     state     <= ST_CMP_ISSUE;
                  end
                  OP_BAR: begin
                     bar_seen <= 1'b0;
                     state    <= ST_BARRIER;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
            ST_LS_ISSUE: begin
               cnt_q   <= cnt_q + 16'd1;
               gap_cnt <= '0;
               state   <= (LS_GAP == 0) ? ST_IDLE : ST_LS_WAIT;
            end
            ST_LS_WAIT: begin
               if (gap_cnt == GAP_LAST) state <= ST_IDLE;
               else                     gap_cnt <= gap_cnt + 4'd1;
            end
            ST_CMP_ISSUE: begin
               if (bus.Compute_ready) begin
                  cnt_q <= cnt_q + 16'd1;
                  state <= ST_IDLE;
               end
            end
            ST_BARRIER: begin
               // Release needs two back-to-back ready cycles; any gap restarts the count.
               if (!bus.Compute_ready) begin
                  bar_seen <= 1'b0;
               end else if (bar_seen) begin
                  bar_seen <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  bar_seen <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ExLdSt_valid    = (state == ST_LS_ISSUE);
   assign bus.ExLdSt_command  = (state == ST_LS_ISSUE) ? instr_q.payload[LS_CMD_W-1:0] : '0;
   assign bus.Compute_valid   = (state == ST_CMP_ISSUE);
   assign bus.Compute_command = cmp_cmd_q;
   assign bus.F_in            = flag_q;
   assign seq_idle            = fifo_empty && (state == ST_IDLE);
   assign issued_cnt          = cnt_q;

endmodule

// File: tb/tb_mul_cmd_sequencer.sv
// Scoreboard bench: expected issues are queued at push time and retired as strobes/handshakes appear.
module tb_mul_cmd_sequencer;
   import mul_cmd_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seq_idle;
   logic [15:0] issued_cnt;

   mul_cmd_sequencer_if bus ();

   mul_cmd_sequencer #(.FIFO_DEPTH(4), .LS_GAP(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .seq_idle   (seq_idle),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_cmp;
      logic [24:0] cmd;
      bit          flag;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          ls_strobes = 0;
   int          cmp_hs = 0;
   int          cmp_hi = 0;
   logic        cmp_prev_vld = 1'b0;
   logic [24:0] cmp_prev_cmd = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [1:0] op, input logic f, input logic [24:0] p);
      return {op, f, 4'b0000, p};
   endfunction

   task tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_instr(input logic [31:0] d);
      int   n = 0;
      exp_t e;
      bus.instr_valid = 1'b1;
      bus.instr_data  = d;
      while (!bus.instr_ready && n < 100) begin
         tick();
         n++;
      end
      chk("push_timeout", 32'(n < 100), 1);
      e.is_cmp = (d[31:30] == OP_CMP);
      e.cmd    = (d[31:30] == OP_LDST) ? {18'b0, d[6:0]} : d[24:0];
      e.flag   = d[29];
      if (d[31:30] == OP_LDST || d[31:30] == OP_CMP) sb.push_back(e);
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic wait_ls(output int n);
      n = 0;
      while (!bus.ExLdSt_valid && n < 50) begin
         tick();
         n++;
      end
      chk("ls_timeout", 32'(n < 50), 1);
   endtask

   task automatic wait_cmp();
      int n = 0;
      while (!bus.Compute_valid && n < 50) begin
         tick();
         n++;
      end
      chk("cmp_timeout", 32'(n < 50), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!seq_idle && n < 100) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(n < 100), 1);
   endtask

   // Retire issues in order against the scoreboard and watch output stability rules.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         cmp_prev_vld = 1'b0;
      end else begin
         if (bus.ExLdSt_valid) begin
            ls_strobes++;
            if (sb.size() == 0) begin
               chk("ls_unexpected", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               chk("ls_kind", 32'(mon_e.is_cmp), 0);
               chk("ls_cmd", 32'(bus.ExLdSt_command), 32'(mon_e.cmd));
               chk("ls_flag", 32'(bus.F_in), 32'(mon_e.flag));
            end
         end else begin
            chk("ls_cmd_zero", 32'(bus.ExLdSt_command), 0);
         end
         if (bus.Compute_valid) begin
            cmp_hi++;
            if (cmp_prev_vld) chk("cmp_stable", 32'(bus.Compute_command), 32'(cmp_prev_cmd));
            cmp_prev_cmd = bus.Compute_command;
            if (bus.Compute_ready) begin
               cmp_hs++;
               if (sb.size() == 0) begin
                  chk("cmp_unexpected", sb.size(), 1);
               end else begin
                  mon_e = sb.pop_front();
                  chk("cmp_kind", 32'(mon_e.is_cmp), 1);
                  chk("cmp_cmd", 32'(bus.Compute_command), 32'(mon_e.cmd));
                  chk("cmp_flag", 32'(bus.F_in), 32'(mon_e.flag));
               end
            end
         end
         cmp_prev_vld = bus.Compute_valid && !bus.Compute_ready;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int base_ls;
      int base_hs;
      bus.instr_valid   = 1'b0;
      bus.instr_data    = '0;
      bus.Compute_ready = 1'b0;
      rst_n             = 1'b0;
      repeat (3) tick();

      chk("rst_ls_valid", 32'(bus.ExLdSt_valid), 0);
      chk("rst_ls_cmd", 32'(bus.ExLdSt_command), 0);
      chk("rst_cmp_valid", 32'(bus.Compute_valid), 0);
      chk("rst_cmp_cmd", 32'(bus.Compute_command), 0);
      chk("rst_f_in", 32'(bus.F_in), 0);
      chk("rst_seq_idle", 32'(seq_idle), 1);
      chk("rst_instr_ready", 32'(bus.instr_ready), 1);
      chk("rst_issued_cnt", 32'(issued_cnt), 0);
      rst_n = 1'b1;
      tick();

      // Single LDST: latency, single pulse, count and load/store gap.
      push_instr(mk(OP_LDST, 1'b1, 25'h5A));
      wait_ls(n);
      chk("ls_latency", n + 1, 3);
      tick();
      chk("ls_pulse_once", 32'(bus.ExLdSt_valid), 0);
      chk("cnt_after_ls", 32'(issued_cnt), 1);
      chk("ls_gap1_busy", 32'(seq_idle), 0);
      tick();
      chk("ls_gap2_busy", 32'(seq_idle), 0);
      tick();
      chk("ls_gap_idle", 32'(seq_idle), 1);

      // COMPUTE stalled five cycles, then handshake.
      cmp_hi = 0;
      push_instr(mk(OP_CMP, 1'b0, 25'h1ABCDEF));
      wait_cmp();
      repeat (5) tick();
      bus.Compute_ready = 1'b1;
      tick();
      bus.Compute_ready = 1'b0;
      chk("cmp_drop", 32'(bus.Compute_valid), 0);
      chk("cmp_hi_cycles", cmp_hi, 6);
      chk("cmp_cmd_hold", 32'(bus.Compute_command), 32'h1ABCDEF);
      chk("cnt_after_cmp", 32'(issued_cnt), 2);

      // Fill the buffer behind a stalled compute; the fifth push waits for a pop.
      push_instr(mk(OP_CMP, 1'b1, 25'h0001111));
      wait_cmp();
      push_instr(mk(OP_LDST, 1'b0, 25'h11));
      push_instr(mk(OP_CMP, 1'b1, 25'h0222222));
      push_instr(mk(OP_LDST, 1'b1, 25'h33));
      push_instr(mk(OP_CMP, 1'b0, 25'h0444444));
      chk("full_ready_low", 32'(bus.instr_ready), 0);
      bus.instr_valid = 1'b1;
      bus.instr_data  = mk(OP_LDST, 1'b0, 25'h55);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_ready_held", 32'(bus.instr_ready), 0);
      end
      bus.Compute_ready = 1'b1;
      push_instr(mk(OP_LDST, 1'b0, 25'h55));
      wait_idle();
      chk("drain_sb_empty", sb.size(), 0);
      chk("cnt_after_fill", 32'(issued_cnt), 8);

      // Barrier released only by two consecutive ready cycles.
      bus.Compute_ready = 1'b0;
      base_ls = ls_strobes;
      push_instr(mk(OP_LDST, 1'b1, 25'h21));
      push_instr(mk(OP_BAR, 1'b0, 25'h0));
      push_instr(mk(OP_LDST, 1'b0, 25'h42));
      repeat (12) tick();
      chk("bar_first_ls", ls_strobes, base_ls + 1);
      bus.Compute_ready = 1'b1;
      tick();
      bus.Compute_ready = 1'b0;
      tick();
      bus.Compute_ready = 1'b1;
      tick();
      chk("bar_no_early", ls_strobes, base_ls + 1);
      tick();
      bus.Compute_ready = 1'b0;
      chk("bar_still_held", ls_strobes, base_ls + 1);
      wait_ls(n);
      chk("bar_release_lat", n, 2);
      wait_idle();
      chk("cnt_after_bar", 32'(issued_cnt), 10);

      // Reset while a compute is outstanding with three entries buffered.
      push_instr(mk(OP_CMP, 1'b1, 25'h0777777));
      wait_cmp();
      push_instr(mk(OP_LDST, 1'b1, 25'h61));
      push_instr(mk(OP_LDST, 1'b0, 25'h62));
      push_instr(mk(OP_LDST, 1'b1, 25'h63));
      rst_n = 1'b0;
      tick();
      chk("rst_mid_cmp_valid", 32'(bus.Compute_valid), 0);
      chk("rst_mid_seq_idle", 32'(seq_idle), 1);
      chk("rst_mid_ready", 32'(bus.instr_ready), 1);
      chk("rst_mid_cnt", 32'(issued_cnt), 0);
      chk("rst_mid_f_in", 32'(bus.F_in), 0);
      sb.delete();
      rst_n             = 1'b1;
      bus.Compute_ready = 1'b1;
      base_ls = ls_strobes;
      base_hs = cmp_hs;
      repeat (20) tick();
      chk("post_rst_no_ls", ls_strobes, base_ls);
      chk("post_rst_no_cmp", cmp_hs, base_hs);
      chk("post_rst_idle", 32'(seq_idle), 1);

      // Counter wrap: NOP must not count, LDST wraps 0xFFFF to 0.
      force dut.cnt_q = 16'hFFFF;
      tick();
      release dut.cnt_q;
      tick();
      chk("cnt_preload", 32'(issued_cnt), 32'hFFFF);
      push_instr(mk(OP_NOP, 1'b1, 25'h7F));
      wait_idle();
      chk("nop_no_count", 32'(issued_cnt), 32'hFFFF);
      chk("nop_no_flag", 32'(bus.F_in), 0);
      push_instr(mk(OP_LDST, 1'b1, 25'h0F));
      wait_ls(n);
      tick();
      chk("cnt_wrap", 32'(issued_cnt), 0);
      wait_idle();
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
